csi2_stream_ctrl: RTL

Stream sequencer between the pixel source (pattern generator / parallel sensor port) and the CMOS-to-D-PHY CSI-2 transmitter core. It holds the D-PHY powered down until enabled, waits for PLL lock and D-PHY init-done, and admits video only from the start of a complete frame. It forwards frame/line valid and pixel data through one register stage, checks frame geometry, and closes frames cleanly on disable or link loss.

---
 rtl/csi2_stream_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/csi2_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : csi2_stream_ctrl
// Brief   : Frame-aligned stream sequencer in front of a CSI-2 D-PHY transmitter.
// Revision: 1.0
// ============================================================================
module csi2_stream_ctrl #(
    parameter int DATA_W       = 24,
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int INIT_TIMEOUT = 4800000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable_i,
    input  logic              pll_lock_i,
    input  logic              tinit_done_i,
    input  logic              fv_i,
    input  logic              lv_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              fv_o,
    output logic              lv_o,
    output logic              dvalid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              pd_dphy_o,
    output logic [1:0]        state_o,
    output logic [15:0]       frame_cnt_o,
    output logic              size_err_o,
    output logic              link_err_o
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_INIT = 2'd1;
    localparam logic [1:0] S_ARMED     = 2'd2;
    localparam logic [1:0] S_STREAM    = 2'd3;

    localparam int              TMO_W    = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(INIT_TIMEOUT - 1);
    localparam logic [15:0]     H_EXP    = 16'(H_ACTIVE);
    localparam logic [15:0]     V_EXP    = 16'(V_ACTIVE);
    localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

    logic [1:0]        state_q, state_d;
    logic              fv_in_q;
    logic              fv_o_q, fv_o_d;
    logic              lv_o_q, lv_o_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              size_err_q, size_err_d;
    logic              link_err_q, link_err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       pix_q, pix_d;
    logic [15:0]       line_q, line_d;

    logic        w_lvf;
    logic        w_fv_rise;
    logic        w_fv_fall;
    logic        w_lock_lost;
    logic        w_admit;
    logic        w_fwd;
    logic        w_lv_fall;
    logic        w_frame_end;
    logic        w_init_ok;
    logic        w_timeout;
    logic        w_start;
    logic [15:0] w_line_inc;

    assign w_lvf       = lv_i & fv_i;
    assign w_fv_rise   = fv_i & ~fv_in_q;
    assign w_fv_fall   = ~fv_i & fv_in_q;
    // Waiting for lock is normal in WAIT_INIT, so only a lock drop after init is an error.
    assign w_lock_lost = ~pll_lock_i & ((state_q == S_ARMED) | (state_q == S_STREAM));
    assign w_admit     = (state_q == S_ARMED) & ~w_lock_lost & enable_i & w_fv_rise;
    assign w_fwd       = ~w_lock_lost & (w_admit | (state_q == S_STREAM));
    assign w_lv_fall   = (state_q == S_STREAM) & ~w_lock_lost & lv_o_q & ~w_lvf;
    assign w_frame_end = (state_q == S_STREAM) & ~w_lock_lost & w_fv_fall;
    assign w_init_ok   = pll_lock_i & tinit_done_i;
    assign w_timeout   = (state_q == S_WAIT_INIT) & enable_i & ~w_init_ok & (tmo_q == TMO_LAST);
    assign w_start     = (state_q == S_IDLE) & enable_i;
    assign w_line_inc  = (w_lv_fall && line_q != CNT_MAX) ? line_q + 16'd1 : line_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                if (!enable_i)      state_d = S_IDLE;
                else if (w_init_ok) state_d = S_ARMED;
                else if (w_timeout) state_d = S_IDLE;
            end
            S_ARMED: begin
                if (w_lock_lost)    state_d = S_WAIT_INIT;
                else if (!enable_i) state_d = S_IDLE;
                else if (w_fv_rise) state_d = S_STREAM;
            end
            default: begin
                if (w_lock_lost)      state_d = S_WAIT_INIT;
                else if (w_fv_fall)   state_d = enable_i ? S_ARMED : S_IDLE;
            end
        endcase
    end

    always_comb begin
        fv_o_d      = w_fwd ? fv_i : 1'b0;
        lv_o_d      = w_fwd ? w_lvf : 1'b0;
        data_d      = (w_fwd && w_lvf) ? data_i : data_q;
        frame_cnt_d = w_frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
        tmo_d       = (state_q == S_WAIT_INIT && state_d == S_WAIT_INIT) ? tmo_q + 1'b1 : '0;

        pix_d = pix_q;
        if (!w_fwd || w_lv_fall)           pix_d = '0;
        else if (w_lvf && pix_q != CNT_MAX) pix_d = pix_q + 16'd1;

        line_d = (!w_fwd || w_frame_end) ? 16'd0 : w_line_inc;

        if (w_start) begin
            size_err_d = 1'b0;
            link_err_d = 1'b0;
        end else begin
            size_err_d = size_err_q
                       | (w_lv_fall && pix_q != H_EXP)
                       | (w_frame_end && w_line_inc != V_EXP)
                       | ((state_q == S_STREAM) & ~w_lock_lost & lv_i & ~fv_i);
            link_err_d = link_err_q | w_lock_lost | w_timeout;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fv_in_q     <= 1'b0;
            fv_o_q      <= 1'b0;
            lv_o_q      <= 1'b0;
            data_q      <= '0;
            frame_cnt_q <= '0;
            size_err_q  <= 1'b0;
            link_err_q  <= 1'b0;
            tmo_q       <= '0;
            pix_q       <= '0;
            line_q      <= '0;
        end else begin
            fv_in_q     <= fv_i;
            fv_o_q      <= fv_o_d;
            lv_o_q      <= lv_o_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
            size_err_q  <= size_err_d;
            link_err_q  <= link_err_d;
            tmo_q       <= tmo_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
        end
    end

    assign fv_o        = fv_o_q;
    assign lv_o        = lv_o_q;
    assign dvalid_o    = lv_o_q;
    assign data_o      = data_q;
    assign pd_dphy_o   = (state_q == S_IDLE);
    assign state_o     = state_q;
    assign frame_cnt_o = frame_cnt_q;
    assign size_err_o  = size_err_q;
    assign link_err_o  = link_err_q;

endmodule
`default_nettype wire
